// File: rtl/ex_stage_pkg.sv
// Shared definitions for the EX stage: ALU operation codes, mul/div FSM states
// and the EX_MEM output bundle.
package ex_stage_pkg;

  typedef enum logic [4:0] {
    AluAdd   = 5'd0,
    AluAddu  = 5'd1,
    AluSub   = 5'd2,
    AluSubu  = 5'd3,
    AluAnd   = 5'd4,
    AluOr    = 5'd5,
    AluXor   = 5'd6,
    AluNor   = 5'd7,
    AluSlt   = 5'd8,
    AluSltu  = 5'd9,
    AluSll   = 5'd10,
    AluSrl   = 5'd11,
    AluSra   = 5'd12,
    AluSllv  = 5'd13,
    AluSrlv  = 5'd14,
    AluSrav  = 5'd15,
    AluMult  = 5'd16,
    AluMultu = 5'd17,
    AluDiv   = 5'd18,
    AluDivu  = 5'd19,
    AluMfhi  = 5'd20,
    AluMflo  = 5'd21,
    AluMthi  = 5'd22,
    AluMtlo  = 5'd23
  } alu_code_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } md_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] data_2;
    logic [4:0]  wr_reg;
    logic        reg_wen;
    logic        dmem_alu;
    logic        jr;
    logic [31:0] jr_target;
    logic        ovf;
  } ex_out_t;

  function automatic logic is_muldiv(logic [4:0] code);
    return (code == AluMult) || (code == AluMultu) || (code == AluDiv) || (code == AluDivu);
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle
// on operand magnitudes, with sign correction on the final step.
module muldiv_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_div,
  input  logic         op_signed,
  input  logic         abort,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         idle,
  output logic         busy,
  output logic         done,
  output logic         res_valid,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  localparam int unsigned CW = $clog2(ITERS);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;   // product high half / partial remainder
  logic [W-1:0]  lo_q, lo_d;     // multiplier / dividend, shifted out as quotient builds
  logic [W-1:0]  opb_q, opb_d;   // multiplicand / divisor magnitude
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic          dz_q, dz_d;

  logic [W:0]     mul_sum;
  logic [W-1:0]   mul_acc_n, mul_lo_n;
  logic [W:0]     div_sh, div_diff;
  logic [W-1:0]   div_acc_n, div_lo_n;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quo_s, rem_s;
  logic           last;

  function automatic logic [W-1:0] mag(logic [W-1:0] v, logic sgn);
    return (sgn && v[W-1]) ? -v : v;
  endfunction

  assign idle = (state_q == StIdle);
  assign busy = (state_q == StMul) || (state_q == StDiv);
  assign done = (state_q == StDone);
  assign last = (cnt_q == CW'(ITERS - 1));

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_acc_n = mul_sum[W:1];
    mul_lo_n  = {mul_sum[0], lo_q[W-1:1]};
    div_sh    = {acc_q, lo_q[W-1]};
    div_diff  = div_sh - {1'b0, opb_q};
    div_acc_n = div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0];
    div_lo_n  = {lo_q[W-2:0], ~div_diff[W]};
    prod      = {mul_acc_n, mul_lo_n};
    prod_s    = negq_q ? -prod : prod;
    // Divide by zero keeps an all-ones quotient regardless of operand signs.
    quo_s     = (negq_q && !dz_q) ? -div_lo_n : div_lo_n;
    rem_s     = negr_q ? -div_acc_n : div_acc_n;
    res_hi    = (state_q == StMul) ? prod_s[2*W-1:W] : rem_s;
    res_lo    = (state_q == StMul) ? prod_s[W-1:0] : quo_s;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dz_d      = dz_q;
    res_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = op_div ? StDiv : StMul;
          cnt_d   = '0;
          acc_d   = '0;
          lo_d    = mag(op_a, op_signed);
          opb_d   = mag(op_b, op_signed);
          negq_d  = op_signed && (op_a[W-1] ^ op_b[W-1]);
          negr_d  = op_signed && op_a[W-1];
          dz_d    = (op_b == '0);
        end
      end
      StMul, StDiv: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          acc_d = (state_q == StMul) ? mul_acc_n : div_acc_n;
          lo_d  = (state_q == StMul) ? mul_lo_n : div_lo_n;
          if (last) begin
            state_d   = StDone;
            cnt_d     = '0;
            res_valid = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS EX stage: combinational ALU, HI/LO registers, iterative mul/div with
// pipeline stall, and the EX_MEM output register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic         flush_in,
  input  logic [W-1:0] data_1_in,
  input  logic [W-1:0] data_2_in,
  input  logic [4:0]   rt_in,
  input  logic [4:0]   rd_in,
  input  logic [4:0]   shamt_in,
  input  logic         reg_wen_in,
  input  logic         reg_des_in,
  input  logic         dmem_alu_in,
  input  logic         jr_in,
  input  logic [4:0]   alu_code_in,
  output logic         stall_out,
  output logic         valid_out,
  output logic [W-1:0] alu_result_out,
  output logic [W-1:0] data_2_out,
  output logic [4:0]   wr_reg_out,
  output logic         reg_wen_out,
  output logic         dmem_alu_out,
  output logic         jr_out,
  output logic [W-1:0] jr_target_out,
  output logic         ovf_out
);

  alu_code_e    op;
  logic         op_md, issue;
  logic         md_idle, md_busy, md_done, md_res_valid;
  logic [W-1:0] md_hi, md_lo;
  logic [W-1:0] hi_q, lo_q;
  logic [W-1:0] add_res, sub_res, alu_res;
  logic         alu_ovf, wen_block;
  ex_out_t      out_q, out_d;

  assign op    = alu_code_e'(alu_code_in);
  assign op_md = is_muldiv(alu_code_in);
  // A single-cycle op executes only when the mul/div unit is not holding the pipe.
  assign issue = valid_in && !flush_in && md_idle && !op_md;

  assign stall_out = !rst && !flush_in && (md_busy || (md_idle && valid_in && op_md));

  muldiv_unit #(
    .W     (W),
    .ITERS (ITERS)
  ) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (valid_in && op_md && !flush_in),
    .op_div    ((op == AluDiv) || (op == AluDivu)),
    .op_signed ((op == AluMult) || (op == AluDiv)),
    .abort     (flush_in),
    .op_a      (data_1_in),
    .op_b      (data_2_in),
    .idle      (md_idle),
    .busy      (md_busy),
    .done      (md_done),
    .res_valid (md_res_valid),
    .res_hi    (md_hi),
    .res_lo    (md_lo)
  );

  always_comb begin
    add_res   = data_1_in + data_2_in;
    sub_res   = data_1_in - data_2_in;
    alu_res   = '0;
    alu_ovf   = 1'b0;
    wen_block = 1'b0;
    case (op)
      AluAdd: begin
        alu_res = add_res;
        alu_ovf = (data_1_in[W-1] == data_2_in[W-1]) && (add_res[W-1] != data_1_in[W-1]);
      end
      AluAddu: alu_res = add_res;
      AluSub: begin
        alu_res = sub_res;
        alu_ovf = (data_1_in[W-1] != data_2_in[W-1]) && (sub_res[W-1] != data_1_in[W-1]);
      end
      AluSubu: alu_res = sub_res;
      AluAnd:  alu_res = data_1_in & data_2_in;
      AluOr:   alu_res = data_1_in | data_2_in;
      AluXor:  alu_res = data_1_in ^ data_2_in;
      AluNor:  alu_res = ~(data_1_in | data_2_in);
      AluSlt:  alu_res = {{(W-1){1'b0}}, $signed(data_1_in) < $signed(data_2_in)};
      AluSltu: alu_res = {{(W-1){1'b0}}, data_1_in < data_2_in};
      AluSll:  alu_res = data_2_in << shamt_in;
      AluSrl:  alu_res = data_2_in >> shamt_in;
      AluSra:  alu_res = $signed(data_2_in) >>> shamt_in;
      AluSllv: alu_res = data_2_in << data_1_in[4:0];
      AluSrlv: alu_res = data_2_in >> data_1_in[4:0];
      AluSrav: alu_res = $signed(data_2_in) >>> data_1_in[4:0];
      AluMfhi: alu_res = hi_q;
      AluMflo: alu_res = lo_q;
      AluMthi, AluMtlo, AluMult, AluMultu, AluDiv, AluDivu: wen_block = 1'b1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    out_d = '0;
    if (flush_in) begin
      out_d = '0;
    end else if (md_done) begin
      // The stalled MULT/DIV retires with no GPR write.
      out_d.valid    = 1'b1;
      out_d.data_2   = data_2_in;
      out_d.wr_reg   = reg_des_in ? rd_in : rt_in;
      out_d.dmem_alu = dmem_alu_in;
    end else if (issue) begin
      out_d.valid     = 1'b1;
      out_d.result    = alu_res;
      out_d.data_2    = data_2_in;
      out_d.wr_reg    = reg_des_in ? rd_in : rt_in;
      out_d.reg_wen   = reg_wen_in && !alu_ovf && !wen_block;
      out_d.dmem_alu  = dmem_alu_in;
      out_d.jr        = jr_in;
      out_d.jr_target = jr_in ? data_1_in : '0;
      out_d.ovf       = alu_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      out_q <= out_d;
      if (md_res_valid) begin
        hi_q <= md_hi;
        lo_q <= md_lo;
      end else if (issue && (op == AluMthi)) begin
        hi_q <= data_1_in;
      end else if (issue && (op == AluMtlo)) begin
        lo_q <= data_1_in;
      end
    end
  end

  assign valid_out      = out_q.valid;
  assign alu_result_out = out_q.result;
  assign data_2_out     = out_q.data_2;
  assign wr_reg_out     = out_q.wr_reg;
  assign reg_wen_out    = out_q.reg_wen;
  assign dmem_alu_out   = out_q.dmem_alu;
  assign jr_out         = out_q.jr;
  assign jr_target_out  = out_q.jr_target;
  assign ovf_out        = out_q.ovf;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, overflow, mul/div with
// stall timing, flush abort, asynchronous reset and JR.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, flush_in, reg_wen_in, reg_des_in, dmem_alu_in, jr_in;
  logic [31:0] data_1_in, data_2_in;
  logic [4:0]  rt_in, rd_in, shamt_in, alu_code_in;
  logic        stall_out, valid_out, reg_wen_out, dmem_alu_out, jr_out, ovf_out;
  logic [31:0] alu_result_out, data_2_out, jr_target_out;
  logic [4:0]  wr_reg_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .flush_in       (flush_in),
    .data_1_in      (data_1_in),
    .data_2_in      (data_2_in),
    .rt_in          (rt_in),
    .rd_in          (rd_in),
    .shamt_in       (shamt_in),
    .reg_wen_in     (reg_wen_in),
    .reg_des_in     (reg_des_in),
    .dmem_alu_in    (dmem_alu_in),
    .jr_in          (jr_in),
    .alu_code_in    (alu_code_in),
    .stall_out      (stall_out),
    .valid_out      (valid_out),
    .alu_result_out (alu_result_out),
    .data_2_out     (data_2_out),
    .wr_reg_out     (wr_reg_out),
    .reg_wen_out    (reg_wen_out),
    .dmem_alu_out   (dmem_alu_out),
    .jr_out         (jr_out),
    .jr_target_out  (jr_target_out),
    .ovf_out        (ovf_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    valid_in    = 1'b1;
    flush_in    = 1'b0;
    alu_code_in = code;
    data_1_in   = a;
    data_2_in   = b;
    shamt_in    = sh;
    reg_wen_in  = 1'b1;
    reg_des_in  = 1'b1;
    dmem_alu_in = 1'b0;
    jr_in       = 1'b0;
    rt_in       = 5'd2;
    rd_in       = 5'd3;
    #1;
  endtask

  task automatic go_idle();
    valid_in = 1'b0;
    flush_in = 1'b0;
    jr_in    = 1'b0;
    #1;
  endtask

  task automatic alu_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
    drive(code, a, b, sh);
    tick();
    chk(tag, alu_result_out, exp);
  endtask

  // Runs a MULT/DIV to retirement and checks the stall length and retire slot.
  task automatic run_md(input string tag, input logic [4:0] code, input logic [31:0] a,
                        input logic [31:0] b);
    int   n;
    logic bubbles_ok;
    drive(code, a, b, 5'd0);
    n = 0;
    bubbles_ok = 1'b1;
    while (stall_out && n < 40) begin
      tick();
      n++;
      if (valid_out !== 1'b0) bubbles_ok = 1'b0;
    end
    chk({tag, " stall cycles"}, 32'(n), 32'd33);
    chk({tag, " bubbles"}, {31'd0, bubbles_ok}, 32'd1);
    tick();
    chk({tag, " retire valid"}, {31'd0, valid_out}, 32'd1);
    chk({tag, " retire wen"}, {31'd0, reg_wen_out}, 32'd0);
    go_idle();
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    alu_op({tag, " LO"}, AluMflo, 32'd0, 32'd0, 5'd0, lo);
    alu_op({tag, " HI"}, AluMfhi, 32'd0, 32'd0, 5'd0, hi);
    go_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    valid_in = 1'b0; flush_in = 1'b0; jr_in = 1'b0; reg_wen_in = 1'b0; reg_des_in = 1'b0;
    dmem_alu_in = 1'b0; data_1_in = '0; data_2_in = '0; rt_in = '0; rd_in = '0;
    shamt_in = '0; alu_code_in = '0;
    tick();
    tick();
    chk("reset valid", {31'd0, valid_out}, 32'd0);
    chk("reset result", alu_result_out, 32'd0);
    chk("reset wen", {31'd0, reg_wen_out}, 32'd0);
    chk("reset stall", {31'd0, stall_out}, 32'd0);
    chk("reset jr", {31'd0, jr_out}, 32'd0);
    rst = 1'b0;
    tick();

    // Add/sub overflow and wrap
    alu_op("ADD ovf result", AluAdd, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000);
    chk("ADD ovf flag", {31'd0, ovf_out}, 32'd1);
    chk("ADD ovf wen", {31'd0, reg_wen_out}, 32'd0);
    chk("ADD ovf valid", {31'd0, valid_out}, 32'd1);
    alu_op("ADDU wrap", AluAddu, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000);
    chk("ADDU wen", {31'd0, reg_wen_out}, 32'd1);
    chk("ADDU ovf", {31'd0, ovf_out}, 32'd0);
    alu_op("SUB ovf result", AluSub, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF);
    chk("SUB ovf flag", {31'd0, ovf_out}, 32'd1);
    alu_op("SUBU wrap", AluSubu, 32'h0, 32'h1, 5'd0, 32'hFFFFFFFF);

    // Shifts, compares, logic
    alu_op("SRA", AluSra, 32'h0, 32'hF0000000, 5'd4, 32'hFF000000);
    alu_op("SLTU", AluSltu, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h1);
    alu_op("SLT", AluSlt, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0);
    chk("wr_reg rd", {27'd0, wr_reg_out}, 32'd3);
    alu_op("SRLV", AluSrlv, 32'h24, 32'hF0000000, 5'd0, 32'h0F000000);
    alu_op("SLL", AluSll, 32'h0, 32'h1, 5'd31, 32'h80000000);
    alu_op("NOR", AluNor, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF);
    alu_op("undefined code", 5'd31, 32'h1234, 32'h5678, 5'd0, 32'h0);
    drive(AluAddu, 32'h1, 32'h2, 5'd0);
    reg_des_in = 1'b0;
    #1;
    tick();
    chk("wr_reg rt", {27'd0, wr_reg_out}, 32'd2);
    chk("data_2 pass", data_2_out, 32'h2);

    // Multiply / divide
    run_md("MULT", AluMult, 32'hFFFFFFFE, 32'h3);
    read_hilo("MULT", 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_md("MULTU", AluMultu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    read_hilo("MULTU", 32'hFFFFFFFE, 32'h00000001);
    run_md("DIV", AluDiv, 32'hFFFFFFF9, 32'h2);
    read_hilo("DIV", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("DIVU0", AluDivu, 32'h5, 32'h0);
    read_hilo("DIVU0", 32'h5, 32'hFFFFFFFF);
    run_md("DIV0", AluDiv, 32'hFFFFFFFB, 32'h0);
    read_hilo("DIV0", 32'hFFFFFFFB, 32'hFFFFFFFF);

    // Flush mid-DIVU leaves HI/LO alone
    drive(AluMthi, 32'hAAAA0000, 32'h0, 5'd0);
    tick();
    drive(AluMtlo, 32'h00005555, 32'h0, 5'd0);
    tick();
    drive(AluDivu, 32'd100, 32'd7, 5'd0);
    chk("DIVU stall start", {31'd0, stall_out}, 32'd1);
    repeat (11) tick();
    chk("DIVU stall iter10", {31'd0, stall_out}, 32'd1);
    flush_in = 1'b1;
    #1;
    chk("flush stall comb", {31'd0, stall_out}, 32'd0);
    tick();
    chk("flush valid", {31'd0, valid_out}, 32'd0);
    go_idle();
    chk("flush stall next", {31'd0, stall_out}, 32'd0);
    repeat (35) tick();
    read_hilo("after flush", 32'hAAAA0000, 32'h00005555);

    // Flush of a single-cycle op
    drive(AluAddu, 32'h1, 32'h1, 5'd0);
    jr_in = 1'b1;
    flush_in = 1'b1;
    #1;
    tick();
    chk("flush bubble valid", {31'd0, valid_out}, 32'd0);
    chk("flush bubble wen", {31'd0, reg_wen_out}, 32'd0);
    chk("flush bubble jr", {31'd0, jr_out}, 32'd0);
    go_idle();

    // Asynchronous reset during MULT
    alu_op("pre-reset ADDU", AluAddu, 32'h1, 32'h1, 5'd0, 32'h2);
    drive(AluMult, 32'd6, 32'd7, 5'd0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async rst result", alu_result_out, 32'd0);
    chk("async rst stall", {31'd0, stall_out}, 32'd0);
    tick();
    go_idle();
    rst = 1'b0;
    tick();
    read_hilo("post-reset", 32'h0, 32'h0);
    run_md("MULT after rst", AluMult, 32'd6, 32'd7);
    read_hilo("MULT after rst", 32'h0, 32'd42);

    // Jump register
    drive(AluAddu, 32'h00400020, 32'h0, 5'd0);
    jr_in = 1'b1;
    #1;
    tick();
    chk("JR out", {31'd0, jr_out}, 32'd1);
    chk("JR target", jr_target_out, 32'h00400020);
    valid_in = 1'b0;
    #1;
    tick();
    chk("JR bubble", {31'd0, jr_out}, 32'd0);
    go_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
